// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared state codes, lamp encodings and grant type for inter_sched
package semaforo_pkg;

   typedef enum logic [2:0] {
      AV_GRN   = 3'd0,
      AV_YEL   = 3'd1,
      ALL_RED  = 3'd2,
      ST_GRN   = 3'd3,
      ST_YEL   = 3'd4,
      PED_WALK = 3'd5
   } state_t;

   // Lamp vectors are {red,yellow,green}
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   typedef enum logic {
      GR_ST  = 1'b0,
      GR_PED = 1'b1
   } grant_t;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - phase timer: clears on request, otherwise counts up and saturates
module phase_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (cnt != '1)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/inter_sched.sv
// rtl/inter_sched.sv - avenue/street/pedestrian intersection controller with round-robin side grants
module inter_sched
   import semaforo_pkg::*;
#(
   parameter int GREEN_MIN = 8,
   parameter int GREEN_MAX = 20,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int WALK_T    = 6,
   parameter int CNT_W     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sen,
   input  logic       ped_req,
   output logic [2:0] Av,
   output logic [2:0] St,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] curr_st
);

   localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

   state_t           state, state_nxt;
   grant_t           last_grant, last_grant_nxt;
   logic             from_av, from_av_nxt;
   logic             st_pend, st_pend_nxt;
   logic             ped_pend, ped_pend_nxt;
   logic [CNT_W-1:0] cnt;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (state_nxt != state),
      .cnt (cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= AV_GRN;
         last_grant <= GR_PED;
         from_av    <= 1'b0;
         st_pend    <= 1'b0;
         ped_pend   <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         from_av    <= from_av_nxt;
         st_pend    <= st_pend_nxt;
         ped_pend   <= ped_pend_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      from_av_nxt    = from_av;
      case (state)
         AV_GRN:
            if (cnt >= GMIN_LAST && (st_pend || ped_pend))
               state_nxt = AV_YEL;
         AV_YEL:
            if (cnt == YEL_LAST) begin
               state_nxt   = ALL_RED;
               from_av_nxt = 1'b1;
            end
         ALL_RED:
            if (cnt == RED_LAST) begin
               state_nxt = AV_GRN;
               // Side phases only follow an avenue phase; ties alternate away from the last grant
               if (from_av) begin
                  if (st_pend && (!ped_pend || last_grant == GR_PED)) begin
                     state_nxt      = ST_GRN;
                     last_grant_nxt = GR_ST;
                  end else if (ped_pend) begin
                     state_nxt      = PED_WALK;
                     last_grant_nxt = GR_PED;
                  end
               end
            end
         ST_GRN:
            if (cnt == GMAX_LAST || (cnt >= GMIN_LAST && !sen))
               state_nxt = ST_YEL;
         ST_YEL:
            if (cnt == YEL_LAST) begin
               state_nxt   = ALL_RED;
               from_av_nxt = 1'b0;
            end
         PED_WALK:
            if (cnt == WALK_LAST) begin
               state_nxt   = ALL_RED;
               from_av_nxt = 1'b0;
            end
         default:
            state_nxt = AV_GRN;
      endcase
   end

   // Clearing on phase entry wins over a request arriving on the same edge
   always_comb begin
      st_pend_nxt  = st_pend  | (sen     && state != ST_GRN);
      ped_pend_nxt = ped_pend | (ped_req && state != PED_WALK);
      if (state_nxt == ST_GRN && state != ST_GRN)
         st_pend_nxt = 1'b0;
      if (state_nxt == PED_WALK && state != PED_WALK)
         ped_pend_nxt = 1'b0;
   end

   always_comb begin
      Av   = LAMP_RED;
      St   = LAMP_RED;
      walk = 1'b0;
      case (state)
         AV_GRN:   Av = LAMP_GRN;
         AV_YEL:   Av = LAMP_YEL;
         ST_GRN:   St = LAMP_GRN;
         ST_YEL:   St = LAMP_YEL;
         PED_WALK: walk = 1'b1;
         default:  ;
      endcase
   end

   assign ped_ack = (state == PED_WALK) && (cnt == '0);
   assign curr_st = state;

endmodule

// File: tb/tb_inter_sched.sv
// tb/tb_inter_sched.sv - directed self-checking bench for inter_sched
module tb_inter_sched;

   localparam logic [2:0] S_AVG = 3'd0, S_AVY = 3'd1, S_RED = 3'd2,
                          S_STG = 3'd3, S_STY = 3'd4, S_PED = 3'd5;

   logic       clk = 1'b0;
   logic       rst, sen, ped_req;
   logic [2:0] Av, St, curr_st;
   logic       walk, ped_ack;

   int tests_run    = 0;
   int tests_failed = 0;
   int ack_seen     = 0;

   inter_sched dut (
      .clk     (clk),
      .rst     (rst),
      .sen     (sen),
      .ped_req (ped_req),
      .Av      (Av),
      .St      (St),
      .walk    (walk),
      .ped_ack (ped_ack),
      .curr_st (curr_st)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_lamps(input logic [2:0] s);
      case (s)
         S_AVG:   return {3'b001, 3'b100, 1'b0};
         S_AVY:   return {3'b010, 3'b100, 1'b0};
         S_STG:   return {3'b100, 3'b001, 1'b0};
         S_STY:   return {3'b100, 3'b010, 1'b0};
         S_PED:   return {3'b100, 3'b100, 1'b1};
         default: return {3'b100, 3'b100, 1'b0};
      endcase
   endfunction

   // One clock, then sample on the falling edge and check safety plus lamp decode
   task automatic step();
      logic bad;
      @(posedge clk);
      @(negedge clk);
      bad = ((Av[0] | Av[1]) & (St[0] | St[1])) |
            (walk & ((Av != 3'b100) | (St != 3'b100)));
      check_eq("safety", int'(bad), 0);
      check_eq("lamps", int'({Av, St, walk}), int'(exp_lamps(curr_st)));
   endtask

   task automatic dwell(input string tag, input logic [2:0] s, input int exp_len);
      int n = 0;
      check_eq({tag, "_state"}, int'(curr_st), int'(s));
      while (curr_st == s && n < 64) begin
         ack_seen += int'(ped_ack);
         step();
         n++;
      end
      check_eq({tag, "_len"}, n, exp_len);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      check_eq("rst_state", int'(curr_st), 0);
      check_eq("rst_av", int'(Av), 1);
      check_eq("rst_st", int'(St), 4);
      check_eq("rst_walk", int'(walk), 0);
      check_eq("rst_ack", int'(ped_ack), 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sen = 1'b0; ped_req = 1'b0;

      // Idle: avenue keeps the crossing
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step();
         check_eq("idle", int'({curr_st, Av, St}), int'({3'd0, 3'b001, 3'b100}));
      end

      // Street held high: max green, then repeat
      do_reset();
      sen = 1'b1;
      dwell("so_avg", S_AVG, 8);
      dwell("so_avy", S_AVY, 3);
      dwell("so_red1", S_RED, 2);
      dwell("so_stg", S_STG, 20);
      dwell("so_sty", S_STY, 3);
      dwell("so_red2", S_RED, 2);
      dwell("so_avg2", S_AVG, 8);
      check_eq("so_again", int'(curr_st), int'(S_AVY));
      sen = 1'b0;

      // Street gap-out at minimum green
      do_reset();
      sen = 1'b1;
      step(); step(); step();
      sen = 1'b0;
      dwell("gap_avg", S_AVG, 5);
      dwell("gap_avy", S_AVY, 3);
      dwell("gap_red1", S_RED, 2);
      dwell("gap_stg", S_STG, 8);
      dwell("gap_sty", S_STY, 3);
      dwell("gap_red2", S_RED, 2);
      check_eq("gap_home", int'(curr_st), int'(S_AVG));

      // Single pedestrian pulse
      do_reset();
      ack_seen = 0;
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      dwell("ped_avg", S_AVG, 7);
      dwell("ped_avy", S_AVY, 3);
      dwell("ped_red1", S_RED, 2);
      check_eq("ped_ack_entry", int'(ped_ack), 1);
      dwell("ped_walk", S_PED, 6);
      check_eq("ped_ack_count", ack_seen, 1);
      dwell("ped_red2", S_RED, 2);
      check_eq("ped_home", int'(curr_st), int'(S_AVG));

      // Both pending: street first, then avenue, then pedestrian
      do_reset();
      ack_seen = 0;
      sen = 1'b1; ped_req = 1'b1;
      step();
      sen = 1'b0; ped_req = 1'b0;
      dwell("both_avg", S_AVG, 7);
      dwell("both_avy", S_AVY, 3);
      dwell("both_red1", S_RED, 2);
      dwell("both_stg", S_STG, 8);
      dwell("both_sty", S_STY, 3);
      dwell("both_red2", S_RED, 2);
      dwell("both_avg2", S_AVG, 8);
      dwell("both_avy2", S_AVY, 3);
      dwell("both_red3", S_RED, 2);
      dwell("both_walk", S_PED, 6);
      check_eq("both_ack_count", ack_seen, 1);
      dwell("both_red4", S_RED, 2);
      check_eq("both_home", int'(curr_st), int'(S_AVG));

      // Reset in the middle of street green drops pending requests
      do_reset();
      sen = 1'b1; ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      dwell("mid_avg", S_AVG, 7);
      dwell("mid_avy", S_AVY, 3);
      dwell("mid_red", S_RED, 2);
      check_eq("mid_in_stg", int'(curr_st), int'(S_STG));
      step(); step(); step();
      sen = 1'b0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         step();
         check_eq("mid_hold", int'(curr_st), int'(S_AVG));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
